// File: rtl/cache_ctrl_fsm_param_pkg.sv
// ---------------------------------------------------------------------------
// cache_ctrl_fsm_param_pkg
// Shared definitions for the parametrised direct-mapped cache controller:
//   - state_t   : controller state encoding (IDLE, WB, FILL, COMP, DONE, WTHRU)
//   - words_for : number of 2-byte words in a line for a given byte-offset width
// ---------------------------------------------------------------------------
package cache_ctrl_fsm_param_pkg;

  // 3-bit encoding leaves 6 and 7 unused; the controller flags them as errors.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WB    = 3'd1,
    ST_FILL  = 3'd2,
    ST_COMP  = 3'd3,
    ST_DONE  = 3'd4,
    ST_WTHRU = 3'd5
  } state_t;

  // Words are two bytes wide, so the lowest offset bit never selects a word.
  function automatic int words_for(input int offset_w);
    return 1 << (offset_w - 1);
  endfunction

endpackage

// File: rtl/mem_lat_tracker.sv
// ---------------------------------------------------------------------------
// mem_lat_tracker
// Follows accepted memory reads through a fixed-latency memory. Every push
// reappears on land exactly MEM_LAT cycles later, which is the cycle the read
// data is valid for the cache write. Reset discards everything in flight.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   push : a memory read was accepted this cycle
//   land : read data accepted MEM_LAT cycles ago is valid this cycle
// ---------------------------------------------------------------------------
module mem_lat_tracker #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic land
);

  logic [MEM_LAT-1:0] pipe_reg;
  logic [MEM_LAT-1:0] pipe_next;

  always_comb begin
    pipe_next    = pipe_reg;
    pipe_next[0] = push;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_next[i] = pipe_reg[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_reg <= '0;
    end else begin
      pipe_reg <= pipe_next;
    end
  end

  assign land = pipe_reg[MEM_LAT-1];

endmodule

// File: rtl/cache_ctrl_fsm_param.sv
// ---------------------------------------------------------------------------
// cache_ctrl_fsm_param
// Direct-mapped cache controller between the CPU memory stage, the cache
// data/tag array and a stallable multi-bank main memory. Handles hits in one
// cycle, dirty-victim write-back, pipelined line fill with a configurable
// memory latency, and optional write-no-allocate (write-through on miss).
// Outputs are combinational from state, counters and inputs.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   Rd, Wr                   : CPU read / write request
//   tag_in, index, offset_in : request address fields
//   hit, dirty, valid        : cache tag match, victim dirty, victim valid
//   tag_out                  : victim tag (used for write-back addresses)
//   stall                    : memory did not accept this cycle's request
//   Done, Stall, CacheHit    : CPU completion pulse, CPU hold, hit indicator
//   err                      : illegal request (Rd&Wr) or illegal state
//   enable, offset, comp,
//   write, valid_in          : cache array controls
//   addr, wr, rd             : main memory address and read/write strobes
// ---------------------------------------------------------------------------
module cache_ctrl_fsm_param
  import cache_ctrl_fsm_param_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 3,
  parameter int MEM_LAT  = 2,
  parameter int WR_ALLOC = 1,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Rd,
  input  logic                Wr,
  input  logic [TAG_W-1:0]    tag_in,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] offset_in,
  input  logic                hit,
  input  logic                dirty,
  input  logic                valid,
  input  logic [TAG_W-1:0]    tag_out,
  input  logic                stall,
  output logic                Done,
  output logic                Stall,
  output logic                CacheHit,
  output logic                err,
  output logic                enable,
  output logic [OFFSET_W-1:0] offset,
  output logic                comp,
  output logic                write,
  output logic                valid_in,
  output logic [ADDR_W-1:0]   addr,
  output logic                wr,
  output logic                rd
);

  localparam int WORDS = words_for(OFFSET_W);
  // One bit wider than a word index so the issue counter can reach WORDS.
  localparam int CNT_W = OFFSET_W;

  state_t              state_reg;
  state_t              state_next;
  logic [CNT_W-1:0]    wcnt_reg;
  logic [CNT_W-1:0]    icnt_reg;
  logic [CNT_W-1:0]    lcnt_reg;
  logic [TAG_W-1:0]    tag_l_reg;
  logic [INDEX_W-1:0]  idx_l_reg;
  logic [OFFSET_W-1:0] off_l_reg;
  logic                wr_l_reg;

  logic req;
  logic conflict;
  logic line_hit;
  logic miss;
  logic capture;
  logic wb_adv;
  logic wb_last;
  logic issue_active;
  logic push;
  logic land;
  logic fill_land;
  logic last_land;

  // Byte offset of a word counter value (words are two bytes).
  function automatic logic [OFFSET_W-1:0] word_off(input logic [CNT_W-1:0] cnt);
    return cnt << 1;
  endfunction

  assign req          = Rd | Wr;
  assign conflict     = Rd & Wr;
  assign line_hit     = hit & valid;
  assign miss         = req & ~conflict & ~line_hit;
  assign capture      = (state_reg == ST_IDLE) & miss;
  assign wb_adv       = (state_reg == ST_WB) & ~stall;
  assign wb_last      = (wcnt_reg == CNT_W'(WORDS - 1));
  assign issue_active = (icnt_reg < CNT_W'(WORDS));
  assign push         = (state_reg == ST_FILL) & issue_active & ~stall;
  assign fill_land    = (state_reg == ST_FILL) & land;
  assign last_land    = fill_land & (lcnt_reg == CNT_W'(WORDS - 1));

  mem_lat_tracker #(.MEM_LAT(MEM_LAT)) u_tracker (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .land (land)
  );

  always_comb begin
    state_next = state_reg;
    Done       = 1'b0;
    Stall      = 1'b1;
    CacheHit   = 1'b0;
    err        = 1'b0;
    enable     = 1'b1;
    offset     = offset_in;
    comp       = 1'b0;
    write      = 1'b0;
    valid_in   = 1'b0;
    addr       = '0;
    wr         = 1'b0;
    rd         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        Stall = 1'b0;
        if (req) begin
          comp  = 1'b1;
          write = Wr & ~Rd;   // a conflicting request never writes the cache
        end
        if (conflict) begin
          err = 1'b1;
        end else if (req && line_hit) begin
          Done     = 1'b1;
          CacheHit = 1'b1;
        end else if (req) begin
          if (Wr && (WR_ALLOC == 0)) begin
            state_next = ST_WTHRU;
          end else if (valid && dirty) begin
            state_next = ST_WB;
          end else begin
            state_next = ST_FILL;
          end
        end
      end

      ST_WB: begin
        wr     = 1'b1;
        offset = word_off(wcnt_reg);
        addr   = {tag_out, idx_l_reg, word_off(wcnt_reg)};
        if (wb_adv && wb_last) begin
          state_next = ST_FILL;
        end
      end

      ST_FILL: begin
        // Issue and landing run concurrently; only the issue side obeys stall.
        rd = issue_active;
        if (issue_active) begin
          addr = {tag_l_reg, idx_l_reg, word_off(icnt_reg)};
        end
        offset   = word_off(lcnt_reg);
        write    = land;
        valid_in = last_land;
        if (last_land) begin
          state_next = ST_COMP;
        end
      end

      ST_COMP: begin
        comp       = 1'b1;
        write      = wr_l_reg;
        offset     = off_l_reg;
        state_next = ST_DONE;
      end

      ST_DONE: begin
        Done       = 1'b1;
        offset     = off_l_reg;
        state_next = ST_IDLE;
      end

      ST_WTHRU: begin
        wr     = 1'b1;
        offset = off_l_reg;
        addr   = {tag_l_reg, idx_l_reg, off_l_reg};
        if (!stall) begin
          state_next = ST_DONE;
        end
      end

      default: begin
        err        = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      wcnt_reg  <= '0;
      icnt_reg  <= '0;
      lcnt_reg  <= '0;
      tag_l_reg <= '0;
      idx_l_reg <= '0;
      off_l_reg <= '0;
      wr_l_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Later states use these copies; the CPU side may change its inputs.
      if (capture) begin
        tag_l_reg <= tag_in;
        idx_l_reg <= index;
        off_l_reg <= offset_in;
        wr_l_reg  <= Wr;
      end
      if (wb_adv) begin
        wcnt_reg <= wb_last ? '0 : wcnt_reg + 1'b1;
      end
      if (last_land) begin
        icnt_reg <= '0;
        lcnt_reg <= '0;
      end else begin
        if (push) begin
          icnt_reg <= icnt_reg + 1'b1;
        end
        if (fill_land) begin
          lcnt_reg <= lcnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/cache_ctrl_fsm_param.md
Name: cache_ctrl_fsm_param

Overview:
Parametrised direct-mapped cache controller FSM, the successor of the fixed 4-word, 2-cycle-memory controller. It sits between the CPU memory stage and the cache data/tag array plus the stallable four-bank main memory.
- Generalised in line size, memory latency and address split.
- Adds latching of the missing request and a write-no-allocate mode.
- Adds explicit error detection for illegal requests.

Parameters:
ADDR_W, 16, byte address width.
INDEX_W, 8, cache index width.
OFFSET_W, 3, byte offset width; words are 2 bytes, so WORDS = 2^(OFFSET_W-1).
MEM_LAT, 2, cycles from an accepted memory read until its data is valid for the cache write (range 1..4).
WR_ALLOC, 1, 1 = write-allocate on write miss; 0 = write-no-allocate.
Derived: TAG_W = ADDR_W-INDEX_W-OFFSET_W.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
Rd  in  1  CPU read request
Wr  in  1  CPU write request
tag_in  in  TAG_W  request tag
index  in  INDEX_W  request index
offset_in  in  OFFSET_W  request byte offset
hit  in  1  cache tag match
dirty  in  1  victim line dirty
valid  in  1  victim line valid
tag_out  in  TAG_W  victim tag
stall  in  1  memory busy; request not accepted this cycle
Done  out  1  request complete (one-cycle pulse)
Stall  out  1  CPU must hold
CacheHit  out  1  request hit in cache
err  out  1  illegal request or illegal state
enable  out  1  cache array enable
offset  out  OFFSET_W  cache word offset
comp  out  1  cache compare mode
write  out  1  cache write
valid_in  out  1  valid bit written into cache
addr  out  ADDR_W  memory address
wr  out  1  memory write
rd  out  1  memory read

Behaviour:
Clocking and reset:
- Single clock, clk. Reset rst is synchronous and active-high.
- After the reset edge: state=IDLE, all counters 0, in-flight tracker cleared (outstanding memory reads are discarded).
- Post-reset outputs with Rd=Wr=0: Done=0, Stall=0, CacheHit=0, err=0, enable=1, comp=0, write=0, valid_in=0, addr=0, wr=0, rd=0, offset=offset_in.

Request capture:
- Outputs are combinational from state, counters and inputs.
- On any miss, tag_in, index, offset_in and Wr are latched in IDLE. All later states use the latched copies, never live inputs.

IDLE:
- Stall=0.
- If req=Rd|Wr: comp=1, offset=offset_in, write=Wr.
- Rd&Wr together: err=1 for that cycle, no cache write, stay IDLE.
- Hit (hit&valid): Done=1 and CacheHit=1 in the same cycle, stay IDLE.
- Miss with Wr & WR_ALLOC=0: go to WTHRU.
- Miss with valid&dirty: go to WB.
- Any other miss: go to FILL.

WB:
- wcnt runs 0..WORDS-1.
- Outputs: wr=1, offset=2*wcnt, addr={tag_out,idx_l,2*wcnt}, comp=0, write=0.
- wcnt advances only when ~stall; after the last word is accepted, go to FILL.

FILL:
- Issue side: icnt runs 0..WORDS-1. While icnt<WORDS: rd=1, addr={tag_l,idx_l,2*icnt}; icnt advances when ~stall.
- Tracker: an MEM_LAT-deep shift register, pushed with rd&~stall. A 1 at the tail is a landing for that cycle.
- Landing side: on a landing, write=1, offset=2*lcnt, lcnt++. The last landing also asserts valid_in=1; next state is COMP.
- Non-landing cycles: write=0.
- Landings continue regardless of stall.
- With no stall, FILL lasts WORDS+MEM_LAT cycles.

COMP:
- comp=1, write=Wr_l, offset=off_l; go to DONE.

DONE:
- Done=1, offset=off_l; go to IDLE.

WTHRU:
- wr=1, addr={tag_l,idx_l,off_l} held while stall.
- When accepted, go to DONE. No cache write, CacheHit=0.

Stall and latency:
- Stall=1 in every state except IDLE.
- Clean miss, no memory stall: Done asserts exactly 2+WORDS+MEM_LAT cycles after the request cycle (8 cycles with defaults).
- Dirty miss adds WORDS cycles, plus any stall cycles.

Illegal state:
- Unreachable encoding: err=1, next state IDLE.

Decomposition:
- Shared include cache_ctrl_defs.vh holds the state encodings (IDLE, WB, FILL, COMP, DONE, WTHRU) and the word-size constant.
- State and counter registers use the existing dff cell.
- One sub-module, mem_lat_tracker (parameter MEM_LAT): inputs push, clk, rst; output land. It is reused by the future 2-way controller.

Test Plan:
1. Defaults, read hit (hit=1,valid=1) -> Done=1, CacheHit=1 same cycle, Stall=0, no rd/wr.
2. Defaults, clean read miss tag_in=5'h03, index=8'h1A, no stall -> rd addrs 16'h18D0/D2/D4/D6 in cycles 1-4; cache writes offsets 0,2,4,6 in cycles 3-6; valid_in in cycle 6; Done in cycle 8.
3. Dirty miss, tag_out=5'h07, stall high for 2 cycles during the first WB word -> wr to 16'h38D0 held 3 cycles, then 38D2/D4/D6, then fill; Done delayed by exactly 2+4 cycles versus scenario 2.
4. WORDS=8 (OFFSET_W=4), MEM_LAT=3, stall pulsed mid-fill -> exactly 8 cache writes with offsets 0..14 in order; valid_in only on the last one.
5. WR_ALLOC=0 write miss, dirty victim -> single wr at {tag_l,idx_l,off_l}, no rd, no cache write, Done after acceptance; Rd&Wr together -> err=1 for one cycle, state stays IDLE.
6. rst asserted in the middle of FILL -> next cycle IDLE, all outputs at reset values, no late cache write from discarded in-flight reads.
